// File: rtl/linescanner_pkg.sv
// Shared types and constants for the line-scanner acquisition scheduler.
package linescanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXPOSE,
        ST_READOUT,
        ST_CHECK,
        ST_WAIT_PERIOD
    } sched_state_e;

    localparam int unsigned MIN_LINE_PERIOD = 4;
    localparam int unsigned STAT_W          = 16;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/linescanner_acquisition_scheduler_if.sv
// Host/capture-side signal bundle of the acquisition scheduler.
interface linescanner_acquisition_scheduler_if #(
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned LINE_W   = 10
) ();
    import linescanner_pkg::*;

    logic                start;
    logic                stop;
    logic                continuous;
    logic [PERIOD_W-1:0] line_period;
    logic                lval;
    logic                pixel_valid;

    logic                scan_enable;
    logic                busy;
    logic                line_start;
    logic                line_done;
    logic                frame_start;
    logic                frame_done;
    logic [LINE_W-1:0]   line_index;
    logic                frame_aborted;
    logic                length_error;
    logic                overrun;
    logic [STAT_W-1:0]   short_lines;
    logic [STAT_W-1:0]   long_lines;
    logic [STAT_W-1:0]   overruns;

    modport master (
        output start, stop, continuous, line_period, lval, pixel_valid,
        input  scan_enable, busy, line_start, line_done, frame_start, frame_done,
        input  line_index, frame_aborted, length_error, overrun,
        input  short_lines, long_lines, overruns
    );

    modport slave (
        input  start, stop, continuous, line_period, lval, pixel_valid,
        output scan_enable, busy, line_start, line_done, frame_start, frame_done,
        output line_index, frame_aborted, length_error, overrun,
        output short_lines, long_lines, overruns
    );

endinterface

// File: rtl/linescanner_line_timer.sv
// Line period timer: reloads to 0, saturates at the period, flags the period boundary.
module linescanner_line_timer #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                pixel_clock,
    input  logic                reset,
    input  logic                reload_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                expired_o
);
    localparam int unsigned CW = PERIOD_W + 1;

    logic [PERIOD_W-1:0] count_q, count_d;
    logic                expired_q, expired_d;

    // expired means the period elapses on the coming edge, so a line start
    // issued from it lands exactly one period after the previous one.
    always_comb begin
        count_d = count_q;
        if (reload_i) begin
            count_d = '0;
        end else if (count_q < period_i) begin
            count_d = count_q + PERIOD_W'(1);
        end
        expired_d = ({1'b0, count_d} + CW'(1)) >= {1'b0, period_i};
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/linescanner_acquisition_scheduler.sv
// Frames the line-scanner capture unit: per-line arming, pixel counting, line/frame events.
// Optional statistics counters are built when LINESCANNER_SCHED_STATS_EN is defined.
module linescanner_acquisition_scheduler
    import linescanner_pkg::*;
#(
    parameter int unsigned PIXELS_PER_LINE = 1024,
    parameter int unsigned LINES_PER_FRAME = 512,
    parameter int unsigned PERIOD_W        = 16,
    parameter int unsigned PIX_W           = 11,
    parameter int unsigned LINE_W          = 10
) (
    input logic pixel_clock,
    input logic reset,
    linescanner_acquisition_scheduler_if.slave bus
);
    localparam logic [PIX_W-1:0]    PIX_EXP    = PIX_W'(PIXELS_PER_LINE);
    localparam logic [LINE_W-1:0]   LINE_LAST  = LINE_W'(LINES_PER_FRAME - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_MIN = PERIOD_W'(MIN_LINE_PERIOD);

    logic                start_q, stop_q, continuous_q;
    logic                lval_q, lval_prev_q, pixel_valid_q;
    logic [PERIOD_W-1:0] line_period_q;

    sched_state_e        state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0]   line_index_q, line_index_d;
    logic                stop_pend_q, stop_pend_d;
    logic                scan_en_q, scan_en_d;
    logic                busy_q, busy_d;
    logic                line_start_q, line_start_d;
    logic                line_done_q, line_done_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_aborted_q, frame_aborted_d;
    logic                length_error_q, length_error_d;
    logic                overrun_q, overrun_d;

    logic timer_reload, timer_expired;
    logic short_inc, long_inc, ovr_inc, stats_clr;
    logic lval_rise, stop_now;

    assign lval_rise = lval_q & ~lval_prev_q;
    assign stop_now  = stop_pend_q | stop_q;

    linescanner_line_timer #(.PERIOD_W(PERIOD_W)) u_line_timer (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .reload_i    (timer_reload),
        .period_i    (period_d),
        .expired_o   (timer_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        period_d        = period_q;
        pix_cnt_d       = pix_cnt_q;
        line_index_d    = line_index_q;
        stop_pend_d     = stop_pend_q;
        line_start_d    = 1'b0;
        line_done_d     = 1'b0;
        frame_start_d   = 1'b0;
        frame_done_d    = 1'b0;
        frame_aborted_d = frame_aborted_q;
        length_error_d  = length_error_q;
        overrun_d       = overrun_q;
        timer_reload    = 1'b0;
        short_inc       = 1'b0;
        long_inc        = 1'b0;
        ovr_inc         = 1'b0;
        stats_clr       = 1'b0;

        if (state_q != ST_IDLE && stop_q) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start_q && !stop_q) begin
                    period_d        = (line_period_q < PERIOD_MIN) ? PERIOD_MIN : line_period_q;
                    line_index_d    = '0;
                    length_error_d  = 1'b0;
                    overrun_d       = 1'b0;
                    frame_aborted_d = 1'b0;
                    stats_clr       = 1'b1;
                    frame_start_d   = 1'b1;
                    line_start_d    = 1'b1;
                    timer_reload    = 1'b1;
                    state_d         = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                // A strobe in the first lval cycle is already a valid pixel.
                if (lval_rise) begin
                    pix_cnt_d = PIX_W'(pixel_valid_q);
                    state_d   = ST_READOUT;
                end
            end
            ST_READOUT: begin
                if (!lval_q) begin
                    state_d = ST_CHECK;
                end else if (pixel_valid_q && !(&pix_cnt_q)) begin
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                end
            end
            ST_CHECK: begin
                line_done_d = 1'b1;
                short_inc   = pix_cnt_q < PIX_EXP;
                long_inc    = pix_cnt_q > PIX_EXP;
                if (pix_cnt_q != PIX_EXP) begin
                    length_error_d = 1'b1;
                end
                if (line_index_q == LINE_LAST || stop_now) begin
                    frame_done_d    = 1'b1;
                    frame_aborted_d = stop_now;
                    stop_pend_d     = 1'b0;
                    if (continuous_q && !stop_now) begin
                        line_index_d  = '0;
                        frame_start_d = 1'b1;
                        state_d       = ST_WAIT_PERIOD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    line_index_d = line_index_q + LINE_W'(1);
                    state_d      = ST_WAIT_PERIOD;
                end
                // Period already used up: the next line can only start late.
                if (state_d == ST_WAIT_PERIOD && timer_expired) begin
                    overrun_d = 1'b1;
                    ovr_inc   = 1'b1;
                end
            end
            ST_WAIT_PERIOD: begin
                if (timer_expired) begin
                    line_start_d = 1'b1;
                    timer_reload = 1'b1;
                    state_d      = ST_EXPOSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        scan_en_d = (state_d == ST_EXPOSE) || (state_d == ST_READOUT);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            start_q         <= 1'b0;
            stop_q          <= 1'b0;
            continuous_q    <= 1'b0;
            lval_q          <= 1'b0;
            lval_prev_q     <= 1'b0;
            pixel_valid_q   <= 1'b0;
            line_period_q   <= '0;
            state_q         <= ST_IDLE;
            period_q        <= '0;
            pix_cnt_q       <= '0;
            line_index_q    <= '0;
            stop_pend_q     <= 1'b0;
            scan_en_q       <= 1'b0;
            busy_q          <= 1'b0;
            line_start_q    <= 1'b0;
            line_done_q     <= 1'b0;
            frame_start_q   <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_aborted_q <= 1'b0;
            length_error_q  <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            start_q         <= bus.start;
            stop_q          <= bus.stop;
            continuous_q    <= bus.continuous;
            lval_q          <= bus.lval;
            lval_prev_q     <= lval_q;
            pixel_valid_q   <= bus.pixel_valid;
            line_period_q   <= bus.line_period;
            state_q         <= state_d;
            period_q        <= period_d;
            pix_cnt_q       <= pix_cnt_d;
            line_index_q    <= line_index_d;
            stop_pend_q     <= stop_pend_d;
            scan_en_q       <= scan_en_d;
            busy_q          <= busy_d;
            line_start_q    <= line_start_d;
            line_done_q     <= line_done_d;
            frame_start_q   <= frame_start_d;
            frame_done_q    <= frame_done_d;
            frame_aborted_q <= frame_aborted_d;
            length_error_q  <= length_error_d;
            overrun_q       <= overrun_d;
        end
    end

`ifdef LINESCANNER_SCHED_STATS_EN
    logic [STAT_W-1:0] short_q, long_q, ovr_q;

    // Statistics survive continuous restarts; only a fresh start clears them.
    always_ff @(posedge pixel_clock) begin
        if (reset || stats_clr) begin
            short_q <= '0;
            long_q  <= '0;
            ovr_q   <= '0;
        end else begin
            if (short_inc) short_q <= stat_inc(short_q);
            if (long_inc)  long_q  <= stat_inc(long_q);
            if (ovr_inc)   ovr_q   <= stat_inc(ovr_q);
        end
    end

    assign bus.short_lines = short_q;
    assign bus.long_lines  = long_q;
    assign bus.overruns    = ovr_q;
`else
    logic unused_stats;
    assign unused_stats    = ^{short_inc, long_inc, ovr_inc, stats_clr};
    assign bus.short_lines = '0;
    assign bus.long_lines  = '0;
    assign bus.overruns    = '0;
`endif

    assign bus.scan_enable   = scan_en_q;
    assign bus.busy          = busy_q;
    assign bus.line_start    = line_start_q;
    assign bus.line_done     = line_done_q;
    assign bus.frame_start   = frame_start_q;
    assign bus.frame_done    = frame_done_q;
    assign bus.line_index    = line_index_q;
    assign bus.frame_aborted = frame_aborted_q;
    assign bus.length_error  = length_error_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_linescanner_acquisition_scheduler.sv
// Directed bench for linescanner_acquisition_scheduler (3 lines of 8 pixels per frame).
module tb_linescanner_acquisition_scheduler;
    import linescanner_pkg::*;

    localparam int unsigned PPL      = 8;
    localparam int unsigned LPF      = 3;
    localparam int unsigned PERIOD_W = 16;
    localparam int unsigned LINE_W   = 10;

`ifdef LINESCANNER_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        int unsigned period;
        int unsigned npix0;
        int unsigned npix1;
        int unsigned npix2;
        int unsigned rd_len;      // 0: lval lasts npix+2 cycles
        int          exp_len_err;
        int          exp_ovr;
        int          exp_short;
        int          exp_long;
        int          exp_ovrs;
    } vec_t;

    logic pixel_clock = 1'b0;
    logic reset;
    int unsigned cyc = 0;
    int total = 0;
    int bad   = 0;

    int unsigned ls_q[$];
    int unsigned ld_q[$];
    int unsigned fs_q[$];
    int unsigned fd_q[$];
    vec_t vecs[5];

    always #5 pixel_clock = ~pixel_clock;

    linescanner_acquisition_scheduler_if #(.PERIOD_W(PERIOD_W), .LINE_W(LINE_W)) bus ();

    linescanner_acquisition_scheduler #(
        .PIXELS_PER_LINE (PPL),
        .LINES_PER_FRAME (LPF),
        .PERIOD_W        (PERIOD_W),
        .PIX_W           (11),
        .LINE_W          (LINE_W)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .bus         (bus)
    );

    always @(posedge pixel_clock) cyc <= cyc + 1;

    // Event log, sampled mid-cycle.
    always @(negedge pixel_clock) begin
        if (bus.line_start)  ls_q.push_back(cyc);
        if (bus.line_done)   ld_q.push_back(cyc);
        if (bus.frame_start) fs_q.push_back(cyc);
        if (bus.frame_done)  fd_q.push_back(cyc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required the test to end");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge pixel_clock);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        ls_q.delete();
        ld_q.delete();
        fs_q.delete();
        fd_q.delete();
    endtask

    task automatic wait_scan(input string name);
        int unsigned n = 0;
        while (!bus.scan_enable && n < 500) begin
            step();
            n++;
        end
        total++;
        if (!bus.scan_enable) begin
            bad++;
            $display("FAIL %s: scan_enable 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    // Capture unit: lval for len cycles, pixel strobes in cycles 1..npix.
    task automatic do_line(input string name, input int unsigned npix, input int unsigned len);
        wait_scan({name, "_wait"});
        for (int c = 0; c < int'(len); c++) begin
            bus.lval        = 1'b1;
            bus.pixel_valid = (c >= 1) && (c <= int'(npix));
            step();
        end
        bus.lval        = 1'b0;
        bus.pixel_valid = 1'b0;
        step();
        chk({name, "_scan_hold"}, int'(bus.scan_enable), 1);
        step();
        chk({name, "_scan_drop"}, int'(bus.scan_enable), 0);
        chk({name, "_done_early"}, int'(bus.line_done), 0);
        step();
        chk({name, "_line_done"}, int'(bus.line_done), 1);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_lat_busy0", int'(bus.busy), 0);
        step();
        chk("start_busy", int'(bus.busy), 1);
        chk("start_scan", int'(bus.scan_enable), 1);
        chk("start_fs", int'(bus.frame_start), 1);
        chk("start_ls", int'(bus.line_start), 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int unsigned np[3];
        string p;
        p = $sformatf("v%0d", idx);
        np[0] = v.npix0;
        np[1] = v.npix1;
        np[2] = v.npix2;
        clear_log();
        bus.line_period = PERIOD_W'(v.period);
        do_start();
        for (int l = 0; l < 3; l++) begin
            do_line($sformatf("%s_l%0d", p, l), np[l], (v.rd_len != 0) ? v.rd_len : np[l] + 2);
        end
        chk({p, "_frame_done"}, int'(bus.frame_done), 1);
        chk({p, "_aborted"}, int'(bus.frame_aborted), 0);
        step();
        chk({p, "_busy_end"}, int'(bus.busy), 0);
        chk({p, "_line_index"}, int'(bus.line_index), LPF - 1);
        chk({p, "_len_err"}, int'(bus.length_error), v.exp_len_err);
        chk({p, "_overrun"}, int'(bus.overrun), v.exp_ovr);
        chk({p, "_short"}, int'(bus.short_lines), STATS ? v.exp_short : 0);
        chk({p, "_long"}, int'(bus.long_lines), STATS ? v.exp_long : 0);
        chk({p, "_ovrs"}, int'(bus.overruns), STATS ? v.exp_ovrs : 0);
        chk({p, "_n_ls"}, ls_q.size(), 3);
        chk({p, "_n_fs"}, fs_q.size(), 1);
        chk({p, "_n_fd"}, fd_q.size(), 1);
        if (ls_q.size() == 3 && ld_q.size() == 3) begin
            for (int k = 1; k < 3; k++) begin
                if (v.exp_ovr != 0)
                    chk($sformatf("%s_ls_after_ld%0d", p, k), int'(ls_q[k] - ld_q[k-1]), 1);
                else
                    chk($sformatf("%s_ls_space%0d", p, k), int'(ls_q[k] - ls_q[k-1]), int'(v.period));
            end
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.continuous  = 1'b0;
        bus.line_period = PERIOD_W'(40);
        bus.lval        = 1'b0;
        bus.pixel_valid = 1'b0;
        reset = 1'b1;
        repeat (3) step();

        chk("rst_flags", int'({bus.scan_enable, bus.busy, bus.line_start, bus.line_done,
                               bus.frame_start, bus.frame_done, bus.frame_aborted,
                               bus.length_error, bus.overrun}), 0);
        chk("rst_line_index", int'(bus.line_index), 0);
        chk("rst_stats", int'({bus.short_lines, bus.long_lines, bus.overruns} != 0), 0);
        reset = 1'b0;
        step();

        //          period  p0 p1  p2 rd  le ov sh lo ovs
        vecs[0] = '{40,     8, 8,  8, 0,  0, 0, 0, 0, 0};
        vecs[1] = '{40,     8, 7,  9, 0,  1, 0, 1, 1, 0};
        vecs[2] = '{10,     8, 8,  8, 15, 0, 1, 0, 0, 2};
        vecs[3] = '{40,     0, 8,  8, 0,  1, 0, 1, 0, 0};
        vecs[4] = '{40,     8, 8, 12, 0,  1, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
            repeat (3) step();
        end

        // Stop during line 0: line completes, frame ends aborted.
        clear_log();
        bus.line_period = PERIOD_W'(40);
        do_start();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        do_line("stop_l0", 8, 10);
        chk("stop_frame_done", int'(bus.frame_done), 1);
        chk("stop_aborted", int'(bus.frame_aborted), 1);
        step();
        chk("stop_busy_end", int'(bus.busy), 0);
        chk("stop_n_ls", ls_q.size(), 1);
        repeat (3) step();

        // start and stop together: stays idle.
        clear_log();
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        repeat (5) step();
        chk("startstop_busy", int'(bus.busy), 0);
        chk("startstop_n_fs", fs_q.size(), 0);

        // Continuous: back-to-back frames, then a normal finish.
        clear_log();
        bus.continuous = 1'b1;
        do_start();
        for (int l = 0; l < 3; l++) do_line($sformatf("cont_a%0d", l), 8, 10);
        chk("cont_fd", int'(bus.frame_done), 1);
        chk("cont_fs", int'(bus.frame_start), 1);
        chk("cont_line_index", int'(bus.line_index), 0);
        chk("cont_busy", int'(bus.busy), 1);
        bus.continuous = 1'b0;
        for (int l = 0; l < 3; l++) do_line($sformatf("cont_b%0d", l), 8, 10);
        chk("cont_end_fd", int'(bus.frame_done), 1);
        chk("cont_end_fs", int'(bus.frame_start), 0);
        step();
        chk("cont_end_busy", int'(bus.busy), 0);
        chk("cont_n_fs", fs_q.size(), 2);
        if (ls_q.size() == 6) chk("cont_frame_gap", int'(ls_q[3] - ls_q[2]), 40);
        else chk("cont_n_ls", ls_q.size(), 6);
        repeat (3) step();

        // Reset in the middle of line 1 readout.
        clear_log();
        do_start();
        do_line("rst_l0", 7, 9);
        chk("rst_pre_len_err", int'(bus.length_error), 1);
        chk("rst_pre_index", int'(bus.line_index), 1);
        wait_scan("rst_l1_wait");
        bus.lval = 1'b1;
        step();
        bus.pixel_valid = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        step();
        chk("midrst_flags", int'({bus.scan_enable, bus.busy, bus.line_start, bus.line_done,
                                  bus.frame_start, bus.frame_done, bus.frame_aborted,
                                  bus.length_error, bus.overrun}), 0);
        chk("midrst_line_index", int'(bus.line_index), 0);
        reset           = 1'b0;
        bus.lval        = 1'b0;
        bus.pixel_valid = 1'b0;
        repeat (5) step();
        chk("midrst_idle", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
